// File: rtl/rr_arbiter_onehot.sv
// Round-robin arbiter: registered one-hot grant with valid/ready handshake.
// Define ARB_IDX_OUT_EN to add the registered binary grant index output gnt_idx.
module rr_arbiter_onehot #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  gnt,
  output logic          gnt_v,
  input  logic          gnt_rdy,
`ifdef ARB_IDX_OUT_EN
  output logic [IW-1:0] gnt_idx,
`endif
  output logic          busy
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [N-1:0]    r_gnt;
  logic [N-1:0]    w_gnt_nxt;
  logic            r_gnt_v;
  logic            w_gnt_v_nxt;
  logic [IW-1:0]   r_idx;
  logic [IW-1:0]   w_idx_nxt;
  logic [IW-1:0]   r_ptr;
  logic [IW-1:0]   w_ptr_nxt;
  logic [IW-1:0]   w_scan_ptr;
  logic [IW-1:0]   w_sel;
  logic [N-1:0]    w_sel_onehot;
  logic            w_any_req;

  // First requester at or after ptr, wrapping modulo N (N is a power of two).
  function automatic logic [IW-1:0] sel_idx(input logic [N-1:0] reqs,
                                            input logic [IW-1:0] ptr);
    logic [IW-1:0] k;
    logic          found;
    sel_idx = {IW{1'b0}};
    found   = 1'b0;
    for (int i = 0; i < N; i++) begin
      k = ptr + IW'(i);
      if (!found && reqs[k]) begin
        sel_idx = k;
        found   = 1'b1;
      end
    end
  endfunction

  // Selection: from IDLE scan from ptr; on accept scan from just past the winner.
  always_comb begin
    w_any_req    = |req;
    w_scan_ptr   = (r_state == S_GRANT) ? (r_idx + {{(IW-1){1'b0}}, 1'b1}) : r_ptr;
    w_sel        = sel_idx(req, w_scan_ptr);
    w_sel_onehot = {{(N-1){1'b0}}, 1'b1} << w_sel;
  end

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_gnt_v_nxt = r_gnt_v;
    w_idx_nxt   = r_idx;
    w_ptr_nxt   = r_ptr;
    case (r_state)
      S_IDLE: begin
        if (w_any_req) begin
          w_gnt_nxt   = w_sel_onehot;
          w_gnt_v_nxt = 1'b1;
          w_idx_nxt   = w_sel;
          w_state_nxt = S_GRANT;
        end else begin
          w_gnt_nxt   = {N{1'b0}};
          w_gnt_v_nxt = 1'b0;
        end
      end
      S_GRANT: begin
        // Grant is committed: req changes are ignored until the consumer accepts.
        if (gnt_rdy) begin
          w_ptr_nxt = w_scan_ptr;
          if (w_any_req) begin
            w_gnt_nxt   = w_sel_onehot;
            w_gnt_v_nxt = 1'b1;
            w_idx_nxt   = w_sel;
          end else begin
            w_gnt_nxt   = {N{1'b0}};
            w_gnt_v_nxt = 1'b0;
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_state_nxt = S_GRANT;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_gnt_nxt   = {N{1'b0}};
        w_gnt_v_nxt = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_gnt   <= {N{1'b0}};
      r_gnt_v <= 1'b0;
      r_idx   <= {IW{1'b0}};
      r_ptr   <= {IW{1'b0}};
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_gnt_v <= w_gnt_v_nxt;
      r_idx   <= w_idx_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  assign gnt   = r_gnt;
  assign gnt_v = r_gnt_v;
  assign busy  = r_gnt_v;
`ifdef ARB_IDX_OUT_EN
  assign gnt_idx = r_idx;
`endif

endmodule

// File: tb/tb_rr_arbiter_onehot.sv
// Scoreboard bench for rr_arbiter_onehot (N=4): directed steps push expected
// outputs; a monitor pops and compares one entry per cycle.
module tb_rr_arbiter_onehot;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] gnt;
  logic       gnt_v;
  logic       gnt_rdy;
  logic       busy;
`ifdef ARB_IDX_OUT_EN
  logic [1:0] gnt_idx;
`endif

  typedef struct {
    logic [3:0] gnt;
    logic [1:0] idx;
    int         step;
  } exp_t;

  exp_t q_exp[$];
  int   checks   = 0;
  int   failures = 0;
  int   step_no  = 0;

  rr_arbiter_onehot #(.N(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .gnt     (gnt),
    .gnt_v   (gnt_v),
    .gnt_rdy (gnt_rdy),
`ifdef ARB_IDX_OUT_EN
    .gnt_idx (gnt_idx),
`endif
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive inputs for the next edge and push the outputs expected after it.
  task automatic step(input logic r, input logic [3:0] rq, input logic rdy,
                      input logic [3:0] eg, input logic [1:0] ei);
    exp_t e;
    @(posedge clk);
    #2;
    rst_n   = r;
    req     = rq;
    gnt_rdy = rdy;
    step_no++;
    e.gnt  = eg;
    e.idx  = ei;
    e.step = step_no;
    q_exp.push_back(e);
  endtask

  // Monitor: compare DUT outputs against the scoreboard one cycle at a time.
  initial begin
    exp_t e;
    logic exp_v;
    forever begin
      @(posedge clk);
      #1;
      if (q_exp.size() > 0) begin
        e = q_exp.pop_front();
        exp_v = |e.gnt;
        checks++;
        if (gnt !== e.gnt) begin
          failures++;
          $display("FAIL gnt step %0d: got %b expected %b", e.step, gnt, e.gnt);
        end
        checks++;
        if (gnt_v !== exp_v) begin
          failures++;
          $display("FAIL gnt_v step %0d: got %b expected %b", e.step, gnt_v, exp_v);
        end
        checks++;
        if (busy !== exp_v) begin
          failures++;
          $display("FAIL busy step %0d: got %b expected %b", e.step, busy, exp_v);
        end
`ifdef ARB_IDX_OUT_EN
        checks++;
        if (gnt_idx !== e.idx) begin
          failures++;
          $display("FAIL gnt_idx step %0d: got %0d expected %0d", e.step, gnt_idx, e.idx);
        end
`endif
      end
    end
  end

  initial begin
    rst_n   = 1'b0;
    req     = 4'b1111;
    gnt_rdy = 1'b0;
    //   rst   req      rdy   exp gnt  exp idx
    // Reset held two edges, then first grant one cycle after release.
    step(1'b0, 4'b1111, 1'b0, 4'b0000, 2'd0);
    step(1'b0, 4'b1111, 1'b0, 4'b0000, 2'd0);
    step(1'b1, 4'b1111, 1'b1, 4'b0001, 2'd0);
    // Rotation with ready held high.
    step(1'b1, 4'b1111, 1'b1, 4'b0010, 2'd1);
    step(1'b1, 4'b1111, 1'b1, 4'b0100, 2'd2);
    step(1'b1, 4'b1111, 1'b1, 4'b1000, 2'd3);
    step(1'b1, 4'b1111, 1'b1, 4'b0001, 2'd0);
    step(1'b1, 4'b0000, 1'b1, 4'b0000, 2'd0);
    // Backpressure with withdrawal of the granted request.
    step(1'b1, 4'b0100, 1'b0, 4'b0100, 2'd2);
    step(1'b1, 4'b0100, 1'b0, 4'b0100, 2'd2);
    step(1'b1, 4'b0000, 1'b0, 4'b0100, 2'd2);
    step(1'b1, 4'b0000, 1'b0, 4'b0100, 2'd2);
    step(1'b1, 4'b0000, 1'b0, 4'b0100, 2'd2);
    step(1'b1, 4'b0000, 1'b1, 4'b0000, 2'd2);
    // Fairness after wrap: ptr=3.
    step(1'b1, 4'b1001, 1'b0, 4'b1000, 2'd3);
    step(1'b1, 4'b1001, 1'b1, 4'b0001, 2'd0);
    step(1'b1, 4'b0000, 1'b1, 4'b0000, 2'd0);
    // Reset mid-grant, request re-issued after release.
    step(1'b1, 4'b0010, 1'b0, 4'b0010, 2'd1);
    step(1'b1, 4'b0010, 1'b0, 4'b0010, 2'd1);
    step(1'b0, 4'b0010, 1'b0, 4'b0000, 2'd0);
    step(1'b1, 4'b0010, 1'b0, 4'b0010, 2'd1);
    step(1'b1, 4'b0000, 1'b1, 4'b0000, 2'd1);
    // Reset with ptr=2 must return the pointer to 0.
    step(1'b1, 4'b1111, 1'b0, 4'b0100, 2'd2);
    step(1'b0, 4'b1111, 1'b0, 4'b0000, 2'd0);
    step(1'b1, 4'b1111, 1'b0, 4'b0001, 2'd0);
    // Single requester is re-granted every cycle.
    step(1'b1, 4'b0001, 1'b1, 4'b0001, 2'd0);
    step(1'b1, 4'b0001, 1'b1, 4'b0001, 2'd0);
    // Request changes ignored while a grant is pending.
    step(1'b1, 4'b0110, 1'b0, 4'b0001, 2'd0);
    step(1'b1, 4'b0110, 1'b1, 4'b0010, 2'd1);
    step(1'b1, 4'b0000, 1'b1, 4'b0000, 2'd1);
    step(1'b1, 4'b0000, 1'b0, 4'b0000, 2'd1);

    repeat (3) @(posedge clk);
    #3;
    checks++;
    if (q_exp.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expected 0", q_exp.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
